uart_fifo: RTL and testbench

UART_FIFO -- requirements
Module: uart_fifo

---
 rtl/uart_fifo.sv | 111 +++++++++++
 tb/tb_uart_fifo.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo.sv
// Byte FIFOs between a host and a UART transceiver. The TX side drains
// through a two-state start/done handshake; the RX side is first-word-fall-through.
module uart_fifo #(
    parameter int depth_log2 = 4
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  tx_push,
    input  logic [7:0]            tx_push_data,
    output logic                  tx_full,
    output logic                  tx_empty,
    output logic [depth_log2:0]   tx_level,
    output logic [7:0]            tx_data,
    output logic                  tx_wr,
    input  logic                  tx_done,
    input  logic [7:0]            rx_data,
    input  logic                  rx_done,
    input  logic                  rx_pop,
    output logic [7:0]            rx_pop_data,
    output logic                  rx_empty,
    output logic [depth_log2:0]   rx_level,
    output logic                  rx_overrun,
    input  logic                  overrun_clr
);
    localparam int DEPTH = 2 ** depth_log2;
    localparam int PTR_W = depth_log2;
    localparam int LVL_W = depth_log2 + 1;
    localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(DEPTH);

    typedef enum logic {
        TX_IDLE,
        TX_WAIT
    } tx_state_t;

    logic [7:0]       tx_mem [DEPTH];
    logic [PTR_W-1:0] tx_wptr, tx_rptr;
    tx_state_t        tx_state, tx_state_nxt;
    logic             tx_pop, tx_push_ok;

    logic [7:0]       rx_mem [DEPTH];
    logic [PTR_W-1:0] rx_wptr, rx_rptr;
    logic             rx_full, rx_pop_ok, rx_wr_ok, rx_drop;

    // A push into a full FIFO still lands when the FSM frees a slot in the same cycle.
    assign tx_pop     = (tx_state == TX_IDLE) && (tx_level != '0);
    assign tx_push_ok = tx_push && (!tx_full || tx_pop);
    assign tx_full    = (tx_level == LVL_MAX);
    assign tx_empty   = (tx_level == '0) && (tx_state == TX_IDLE);

    always_comb begin
        tx_state_nxt = tx_state;
        case (tx_state)
            TX_IDLE: if (tx_level != '0) tx_state_nxt = TX_WAIT;
            TX_WAIT: if (tx_done) tx_state_nxt = TX_IDLE;
            default: tx_state_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (tx_push_ok) tx_mem[tx_wptr] <= tx_push_data;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            tx_wptr  <= '0;
            tx_rptr  <= '0;
            tx_level <= '0;
            tx_state <= TX_IDLE;
            tx_wr    <= 1'b0;
            tx_data  <= '0;
        end else begin
            tx_state <= tx_state_nxt;
            tx_wr    <= tx_pop;
            if (tx_pop) begin
                tx_data <= tx_mem[tx_rptr];
                tx_rptr <= tx_rptr + PTR_W'(1);
            end
            if (tx_push_ok) tx_wptr <= tx_wptr + PTR_W'(1);
            if (tx_push_ok && !tx_pop)      tx_level <= tx_level + LVL_W'(1);
            else if (tx_pop && !tx_push_ok) tx_level <= tx_level - LVL_W'(1);
        end
    end

    // RX write is allowed into a full FIFO only when a pop frees the head this cycle.
    assign rx_full     = (rx_level == LVL_MAX);
    assign rx_empty    = (rx_level == '0);
    assign rx_pop_ok   = rx_pop && !rx_empty;
    assign rx_wr_ok    = rx_done && (!rx_full || rx_pop_ok);
    assign rx_drop     = rx_done && !rx_wr_ok;
    assign rx_pop_data = rx_mem[rx_rptr];

    always_ff @(posedge sys_clk) begin
        if (rx_wr_ok) rx_mem[rx_wptr] <= rx_data;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rx_wptr    <= '0;
            rx_rptr    <= '0;
            rx_level   <= '0;
            rx_overrun <= 1'b0;
        end else begin
            if (rx_wr_ok)  rx_wptr <= rx_wptr + PTR_W'(1);
            if (rx_pop_ok) rx_rptr <= rx_rptr + PTR_W'(1);
            if (rx_wr_ok && !rx_pop_ok)      rx_level <= rx_level + LVL_W'(1);
            else if (rx_pop_ok && !rx_wr_ok) rx_level <= rx_level - LVL_W'(1);
            if (rx_drop)          rx_overrun <= 1'b1;
            else if (overrun_clr) rx_overrun <= 1'b0;
        end
    end
endmodule

// File: tb/tb_uart_fifo.sv
// Scoreboard bench for uart_fifo: expected TX bytes are queued at push time and
// matched on tx_wr; expected RX bytes are queued on accepted rx_done and matched on pop.
module tb_uart_fifo;
    logic       sys_clk = 1'b0;
    logic       sys_rst, tx_push, tx_done, rx_done, rx_pop, overrun_clr;
    logic [7:0] tx_push_data, rx_data, tx_data, rx_pop_data;
    logic       tx_full, tx_empty, tx_wr, rx_empty, rx_overrun;
    logic [4:0] tx_level, rx_level;

    int n_checks = 0;
    int n_err = 0;
    int wr_cnt = 0;
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];

    uart_fifo #(.depth_log2(4)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .tx_push(tx_push), .tx_push_data(tx_push_data),
        .tx_full(tx_full), .tx_empty(tx_empty), .tx_level(tx_level),
        .tx_data(tx_data), .tx_wr(tx_wr), .tx_done(tx_done),
        .rx_data(rx_data), .rx_done(rx_done), .rx_pop(rx_pop),
        .rx_pop_data(rx_pop_data), .rx_empty(rx_empty), .rx_level(rx_level),
        .rx_overrun(rx_overrun), .overrun_clr(overrun_clr)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic wait_wr(input int budget);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (tx_wr) seen = 1;
        end
        if (!seen) chk("tx_wr_timeout", 0, 1);
    endtask

    task automatic rx_inject(input logic [7:0] b);
        rx_done = 1'b1;
        rx_data = b;
        tick();
        rx_done = 1'b0;
    endtask

    task automatic rx_pop_chk(input string tag);
        logic [7:0] e;
        if (rx_q.size() == 0) begin
            chk({tag, "_underflow"}, 1, 0);
        end else begin
            e = rx_q.pop_front();
            chk(tag, rx_pop_data, e);
        end
        rx_pop = 1'b1;
        tick();
        rx_pop = 1'b0;
    endtask

    // TX scoreboard: every start strobe must carry the oldest outstanding byte.
    always @(negedge sys_clk) begin
        if (tx_wr === 1'b1) begin
            wr_cnt++;
            if (tx_q.size() == 0) chk("tx_wr_unexpected", 1, 0);
            else chk("tx_data", tx_data, tx_q.pop_front());
        end
    end

    initial begin
        int w;
        int m;
        bit dn, pp, pok, wok;
        logic [7:0] b;

        sys_rst = 1'b1; tx_push = 0; tx_push_data = 0; tx_done = 0;
        rx_done = 0; rx_data = 0; rx_pop = 0; overrun_clr = 0;
        tick(); tick();
        chk("rst_tx_level", tx_level, 0);
        chk("rst_tx_empty", tx_empty, 1);
        chk("rst_tx_full", tx_full, 0);
        chk("rst_tx_wr", tx_wr, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_rx_empty", rx_empty, 1);
        chk("rst_rx_level", rx_level, 0);
        chk("rst_rx_overrun", rx_overrun, 0);
        sys_rst = 1'b0;
        tick();

        // two bytes, transceiver answers 20 cycles after each start
        tx_push = 1; tx_push_data = 8'h41; tx_q.push_back(8'h41);
        tick();
        chk("lat_level1", tx_level, 1);
        chk("lat_no_wr_yet", tx_wr, 0);
        tx_push_data = 8'h42; tx_q.push_back(8'h42);
        tick();
        tx_push = 0;
        chk("lat_wr", tx_wr, 1);
        chk("push_pop_level", tx_level, 1);
        w = wr_cnt;
        for (int i = 0; i < 19; i++) tick();
        chk("no_wr_in_wait", wr_cnt - w, 1);
        tx_done = 1; tick(); tx_done = 0;
        chk("no_wr_on_done", tx_wr, 0);
        tick();
        chk("second_wr", tx_wr, 1);
        for (int i = 0; i < 19; i++) tick();
        tx_done = 1; tick(); tx_done = 0;
        tick();
        chk("two_byte_empty", tx_empty, 1);
        chk("two_byte_wrs", wr_cnt, 2);

        // tx_done while idle must be ignored
        tx_done = 1; tick(); tx_done = 0;
        chk("idle_done_empty", tx_empty, 1);

        // fill: 17 pushes, one issued, 16 held
        for (int i = 0; i < 17; i++) begin
            tx_push = 1; tx_push_data = 8'h60 + 8'(i); tx_q.push_back(tx_push_data);
            tick();
        end
        tx_push = 0;
        chk("fill_level", tx_level, 16);
        chk("fill_full", tx_full, 1);
        tx_push = 1; tx_push_data = 8'hEE; tick(); tx_push = 0;
        chk("full_push_level", tx_level, 16);
        chk("full_push_full", tx_full, 1);
        // push while full, accepted because the FSM pops the same cycle
        tx_done = 1; tick(); tx_done = 0;
        tx_push = 1; tx_push_data = 8'h77; tx_q.push_back(8'h77);
        tick();
        tx_push = 0;
        chk("full_pushpop_wr", tx_wr, 1);
        chk("full_pushpop_level", tx_level, 16);
        for (int i = 0; i < 16; i++) begin
            tx_done = 1; tick(); tx_done = 0;
            wait_wr(4);
        end
        tx_done = 1; tick(); tx_done = 0;
        tick();
        chk("drain_empty", tx_empty, 1);
        chk("drain_q", tx_q.size(), 0);

        // reset mid-operation: FSM in WAIT, 5 bytes queued, RX partly filled
        for (int i = 0; i < 6; i++) begin
            tx_push = 1; tx_push_data = 8'h90 + 8'(i); tx_q.push_back(tx_push_data);
            tick();
        end
        tx_push = 0;
        chk("pre_rst_level", tx_level, 5);
        for (int i = 0; i < 3; i++) rx_inject(8'h30 + 8'(i));
        sys_rst = 1; tick(); sys_rst = 0;
        tx_q.delete();
        rx_q.delete();
        chk("mid_rst_tx_level", tx_level, 0);
        chk("mid_rst_tx_empty", tx_empty, 1);
        chk("mid_rst_rx_level", rx_level, 0);
        w = wr_cnt;
        tick();
        chk("post_rst_no_wr", tx_wr, 0);
        for (int i = 0; i < 5; i++) tick();
        chk("post_rst_wr_cnt", wr_cnt - w, 0);
        tx_push = 1; tx_push_data = 8'hA5; tx_q.push_back(8'hA5); tick(); tx_push = 0;
        wait_wr(3);
        tx_done = 1; tick(); tx_done = 0;

        // RX: fill 16, drop the 17th, drain in order
        for (int i = 0; i < 16; i++) begin
            rx_q.push_back(8'(i));
            rx_inject(8'(i));
        end
        chk("rx_full_level", rx_level, 16);
        rx_inject(8'hFF);
        chk("rx_overrun_set", rx_overrun, 1);
        chk("rx_drop_level", rx_level, 16);
        for (int i = 0; i < 16; i++) rx_pop_chk("rx_order");
        chk("rx_drained_empty", rx_empty, 1);
        rx_pop = 1; tick(); rx_pop = 0;
        chk("rx_pop_empty_level", rx_level, 0);
        overrun_clr = 1; tick(); overrun_clr = 0;
        chk("rx_overrun_clr", rx_overrun, 0);

        // full FIFO with simultaneous rx_done and rx_pop
        for (int i = 0; i < 16; i++) begin
            rx_q.push_back(8'h20 + 8'(i));
            rx_inject(8'h20 + 8'(i));
        end
        chk("rx_head_full", rx_pop_data, rx_q.pop_front());
        rx_q.push_back(8'h55);
        rx_done = 1; rx_data = 8'h55; rx_pop = 1; tick();
        rx_done = 0; rx_pop = 0;
        chk("rx_dp_level", rx_level, 16);
        chk("rx_dp_overrun", rx_overrun, 0);
        // set and clear together resolve to set
        rx_done = 1; rx_data = 8'h66; overrun_clr = 1; tick();
        rx_done = 0; overrun_clr = 0;
        chk("ovr_set_wins", rx_overrun, 1);
        overrun_clr = 1; tick(); overrun_clr = 0;
        chk("ovr_clr_alone", rx_overrun, 0);
        for (int i = 0; i < 16; i++) rx_pop_chk("rx_dp_order");
        chk("rx_dp_empty", rx_empty, 1);

        // random interleave against an occupancy model
        m = 0;
        for (int i = 0; i < 300; i++) begin
            dn = ($urandom_range(0, 99) < 60);
            pp = ($urandom_range(0, 99) < 40);
            b = 8'($urandom);
            pok = pp && (m > 0);
            wok = dn && (m < 16 || pok);
            if (pok) chk("rnd_pop", rx_pop_data, rx_q.pop_front());
            if (wok) rx_q.push_back(b);
            m = m + (wok ? 1 : 0) - (pok ? 1 : 0);
            rx_done = dn; rx_data = b; rx_pop = pp;
            tick();
            if (dn && !wok) chk("rnd_overrun", rx_overrun, 1);
        end
        rx_done = 0; rx_pop = 0;
        chk("rnd_level", rx_level, m);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end
endmodule
